// File: rtl/ex_mem_flag_stage.sv
// EX/MEM pipeline register with the architectural Z/V/N flag register.
// Branch decisions in decode see the flags the EX instruction is about to write.
module ex_mem_flag_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [2:0]  ex_alu_op,
    input  logic [15:0] ex_result,
    input  logic        ex_ovfl,
    input  logic        ex_zero,
    input  logic        ex_sign,
    input  logic        ex_flag_en,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_wr,
    input  logic [2:0]  br_cond,
    output logic        mem_valid,
    output logic        mem_reg_wr,
    output logic [15:0] mem_result,
    output logic [3:0]  mem_rd,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_n,
    output logic        br_taken
);

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_W  = 4;

    typedef enum logic [2:0] {
        OP_ADD    = 3'b000,
        OP_SUB    = 3'b001,
        OP_XOR    = 3'b010,
        OP_RED    = 3'b011,
        OP_SLL    = 3'b100,
        OP_SRA    = 3'b101,
        OP_ROR    = 3'b110,
        OP_PADDSB = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        BR_NE  = 3'b000,
        BR_EQ  = 3'b001,
        BR_GT  = 3'b010,
        BR_LT  = 3'b011,
        BR_GE  = 3'b100,
        BR_LE  = 3'b101,
        BR_OV  = 3'b110,
        BR_ALW = 3'b111
    } br_cond_e;

    alu_op_e  op;
    br_cond_e cond;
    logic     upd;
    logic     z_nxt;
    logic     v_nxt;
    logic     n_nxt;

    assign op   = alu_op_e'(ex_alu_op);
    assign cond = br_cond_e'(br_cond);

    // Nothing is live while reset is held, so the bypass sees the cleared flags.
    assign upd = ex_valid & ~flush & ~stall & ~rst;

    // Next-state flags: only the bits the opcode owns are written.
    always_comb begin
        z_nxt = flag_z;
        v_nxt = flag_v;
        n_nxt = flag_n;
        if (upd && ex_flag_en) begin
            case (op)
                OP_ADD, OP_SUB: begin
                    z_nxt = ex_zero;
                    v_nxt = ex_ovfl;
                    n_nxt = ex_sign;
                end
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: begin
                    z_nxt = ex_zero;
                end
                default: begin
                end
            endcase
        end
    end

    // Branch decision on the bypassed flags; the consumer applies stall.
    always_comb begin
        br_taken = 1'b0;
        case (cond)
            BR_NE:   br_taken = ~z_nxt;
            BR_EQ:   br_taken = z_nxt;
            BR_GT:   br_taken = ~z_nxt & ~n_nxt;
            BR_LT:   br_taken = n_nxt;
            BR_GE:   br_taken = z_nxt | (~z_nxt & ~n_nxt);
            BR_LE:   br_taken = n_nxt | z_nxt;
            BR_OV:   br_taken = v_nxt;
            BR_ALW:  br_taken = 1'b1;
            default: br_taken = 1'b0;
        endcase
    end

    // Pipeline register: flush squashes valid/wr only, stall holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid  <= 1'b0;
            mem_reg_wr <= 1'b0;
            mem_result <= DATA_W'(0);
            mem_rd     <= REG_W'(0);
        end else if (flush) begin
            mem_valid  <= 1'b0;
            mem_reg_wr <= 1'b0;
        end else if (!stall) begin
            mem_valid  <= ex_valid;
            mem_reg_wr <= ex_valid & ex_reg_wr;
            mem_result <= ex_result;
            mem_rd     <= ex_rd;
        end
    end

    // Flag register; next-state already holds under flush/stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            flag_z <= z_nxt;
            flag_v <= v_nxt;
            flag_n <= n_nxt;
        end
    end

endmodule

// File: tb/tb_ex_mem_flag_stage.sv
// Self-checking bench for ex_mem_flag_stage: directed cases plus randomized
// traffic compared every cycle against a behavioural model of the stage.
module tb_ex_mem_flag_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, ex_valid;
    logic [2:0]  ex_alu_op;
    logic [15:0] ex_result;
    logic        ex_ovfl, ex_zero, ex_sign, ex_flag_en;
    logic [3:0]  ex_rd;
    logic        ex_reg_wr;
    logic [2:0]  br_cond;
    logic        mem_valid, mem_reg_wr;
    logic [15:0] mem_result;
    logic [3:0]  mem_rd;
    logic        flag_z, flag_v, flag_n, br_taken;

    int vectors = 0;
    int errors  = 0;

    // Model state; flags packed as {z, v, n}
    logic        m_valid, m_wr;
    logic [15:0] m_res;
    logic [3:0]  m_rd;
    logic [2:0]  m_flags;

    ex_mem_flag_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_result(ex_result),
        .ex_ovfl(ex_ovfl), .ex_zero(ex_zero), .ex_sign(ex_sign),
        .ex_flag_en(ex_flag_en), .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr),
        .br_cond(br_cond), .mem_valid(mem_valid), .mem_reg_wr(mem_reg_wr),
        .mem_result(mem_result), .mem_rd(mem_rd), .flag_z(flag_z),
        .flag_v(flag_v), .flag_n(flag_n), .br_taken(br_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Flags after the coming edge, from the opcode's write set.
    function automatic logic [2:0] flags_after(input logic [2:0] cur);
        if (rst || !ex_valid || flush || stall || !ex_flag_en) return cur;
        case (ex_alu_op)
            3'd0, 3'd1:             return {ex_zero, ex_ovfl, ex_sign};
            3'd2, 3'd4, 3'd5, 3'd6: return {ex_zero, cur[1], cur[0]};
            default:                return cur;
        endcase
    endfunction

    function automatic logic branch(input logic [2:0] c, input logic [2:0] f);
        logic z, v, n;
        {z, v, n} = f;
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        m_valid = 0; m_wr = 0; m_res = '0; m_rd = '0; m_flags = '0;
    endtask

    task automatic model_edge();
        m_flags = flags_after(m_flags);
        if (flush) begin
            m_valid = 0; m_wr = 0;
        end else if (!stall) begin
            m_valid = ex_valid; m_wr = ex_valid && ex_reg_wr;
            m_res = ex_result; m_rd = ex_rd;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_mem_valid"},  32'(mem_valid),  32'(m_valid));
        chk({tag, "_mem_reg_wr"}, 32'(mem_reg_wr), 32'(m_wr));
        chk({tag, "_mem_result"}, 32'(mem_result), 32'(m_res));
        chk({tag, "_mem_rd"},     32'(mem_rd),     32'(m_rd));
        chk({tag, "_flags"},      32'({flag_z, flag_v, flag_n}), 32'(m_flags));
    endtask

    task automatic check_br(input string tag);
        #1 chk({tag, "_br_taken"}, 32'(br_taken), 32'(branch(br_cond, flags_after(m_flags))));
    endtask

    // One full cycle with the currently driven inputs.
    task automatic cycle(input string tag);
        check_br(tag);
        @(posedge clk);
        model_edge();
        #1 check_regs(tag);
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] res,
                         input logic ov, input logic ze, input logic si, input logic fe,
                         input logic [3:0] rd, input logic rw, input logic [2:0] c,
                         input logic st, input logic fl);
        ex_valid = v; ex_alu_op = op; ex_result = res; ex_ovfl = ov; ex_zero = ze;
        ex_sign = si; ex_flag_en = fe; ex_rd = rd; ex_reg_wr = rw; br_cond = c;
        stall = st; flush = fl;
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 3'd0, 16'h0, 0, 0, 0, 0, 4'h0, 0, 3'd0, 0, 0);
        model_reset();
        #2;
        check_regs("reset");
        chk("reset_br_ne", 32'(br_taken), 32'd1);
        #4 rst = 1'b0;

        // ADD 7FFF+1000 -> 8FFF, V=1 N=1 Z=0
        drive(1, 3'd0, 16'h8FFF, 1, 0, 1, 1, 4'h3, 1, 3'd6, 0, 0);
        cycle("add_ovfl");
        chk("add_ovfl_lit_flags", 32'({flag_z, flag_v, flag_n}), 32'h3);
        chk("add_ovfl_lit_result", 32'(mem_result), 32'h8FFF);
        chk("add_ovfl_lit_valid", 32'(mem_valid), 32'd1);

        // XOR writes Z only
        drive(1, 3'd2, 16'h0000, 0, 1, 0, 1, 4'h4, 1, 3'd1, 0, 0);
        cycle("xor_zonly");
        chk("xor_zonly_lit_flags", 32'({flag_z, flag_v, flag_n}), 32'h7);

        // Clear flags, then SUB zero=1 bypass into EQ
        drive(1, 3'd0, 16'h0001, 0, 0, 0, 1, 4'h5, 1, 3'd0, 0, 0);
        cycle("add_clear");
        drive(1, 3'd1, 16'h0000, 0, 1, 0, 1, 4'h6, 1, 3'd1, 0, 0);
        #1 chk("sub_bypass_lit_br", 32'(br_taken), 32'd1);
        stall = 1'b1;
        #1 chk("sub_stall_lit_br", 32'(br_taken), 32'd0);
        cycle("sub_stalled");
        chk("sub_stalled_lit_flags", 32'({flag_z, flag_v, flag_n}), 32'h0);

        // PADDSB / RED leave the flags alone
        drive(1, 3'd7, 16'h1234, 1, 1, 1, 1, 4'h7, 1, 3'd6, 0, 0);
        cycle("paddsb");
        chk("paddsb_lit_flags", 32'({flag_z, flag_v, flag_n}), 32'h0);
        chk("paddsb_lit_result", 32'(mem_result), 32'h1234);
        drive(1, 3'd3, 16'h5678, 1, 1, 1, 1, 4'h8, 1, 3'd1, 0, 0);
        cycle("red");
        chk("red_lit_flags", 32'({flag_z, flag_v, flag_n}), 32'h0);
        chk("red_lit_result", 32'(mem_result), 32'h5678);

        // flush + stall together: squash, flags hold, result holds
        drive(1, 3'd0, 16'hAAAA, 1, 1, 1, 1, 4'h9, 1, 3'd1, 1, 1);
        cycle("flush_stall");
        chk("flush_stall_lit_valid", 32'({mem_valid, mem_reg_wr}), 32'd0);
        chk("flush_stall_lit_flags", 32'({flag_z, flag_v, flag_n}), 32'h0);
        chk("flush_stall_lit_result", 32'(mem_result), 32'h5678);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drive($urandom_range(3) != 0, 3'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(3) != 0,
                  4'($urandom), 1'($urandom), 3'($urandom),
                  $urandom_range(4) == 0, $urandom_range(6) == 0);
            cycle("rand");
        end

        // Async reset mid-cycle with mem_valid=1 and Z=1
        drive(1, 3'd2, 16'h0000, 0, 1, 0, 1, 4'hA, 1, 3'd1, 0, 0);
        cycle("pre_reset");
        chk("pre_reset_lit_state", 32'({mem_valid, flag_z}), 32'h3);
        #2 rst = 1'b1;
        model_reset();
        #1 check_regs("async_reset");
        chk("async_reset_br_eq", 32'(br_taken), 32'd0);
        br_cond = 3'd0;
        #1 chk("async_reset_br_ne", 32'(br_taken), 32'd1);
        #1 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive($urandom_range(3) != 0, 3'($urandom), 16'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  4'($urandom), 1'($urandom), 3'($urandom),
                  $urandom_range(4) == 0, $urandom_range(6) == 0);
            cycle("post_reset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
